pooling_controller: RTL and testbench

//  Streaming KxK sliding-window max-pooling engine with an AXI4-Lite control port.

---
 rtl/pooling_controller.sv | 269 ++++++++++++++++++++++++++
 tb/tb_pooling_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pooling_controller.sv
// Streaming KxK sliding-window max-pooling engine with an AXI4-Lite control port.
// K-1 line buffers feed a per-channel window register; one pooled sample per full window.
module pooling_controller #(
    parameter int KERNEL_SIZE = 3,
    parameter int CHANNELS    = 1,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 10,
    parameter int MAX_WIDTH   = 512
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset_n,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    input  logic [31:0]           s_axis_data,
    input  logic [3:0]            s_axis_keep,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic [31:0]           m_axis_data,
    output logic [3:0]            m_axis_keep,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  s_axi_rlast
);
    localparam int K     = KERNEL_SIZE;
    localparam int NT    = K * K;
    localparam int TW    = (NT > 1) ? $clog2(NT) : 1;
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DEPTH = MAX_WIDTH * CHANNELS;
    localparam int LW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW    = ADDR_WIDTH - 2;

    localparam logic [WW-1:0] A_CTRL = WW'(0);
    localparam logic [WW-1:0] A_SRST = WW'(1);
    localparam logic [WW-1:0] A_STAT = WW'(2);
    localparam logic [WW-1:0] A_WID  = WW'(4);
    localparam logic [WW-1:0] A_HGT  = WW'(5);
    localparam logic [WW-1:0] A_MASK = WW'(6);
    localparam logic [WW-1:0] A_MEND = WW'(6 + NT);
    localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
    localparam logic [15:0]   K_M1    = 16'(K - 1);
    localparam logic [15:0]   K_DIM   = 16'(K);

    logic          enable;
    logic          busy;
    logic          done;
    logic [15:0]   width;
    logic [15:0]   height;
    logic [NT-1:0] mask;
    logic [CW-1:0] chan;
    logic [15:0]   col;
    logic [15:0]   row;

    logic [WW-1:0] wr_word;
    logic [WW-1:0] rd_word;
    logic [TW-1:0] wr_tap;
    logic [TW-1:0] rd_tap;
    logic          wr_fire;
    logic          soft_rst;
    logic          en_rise;
    logic          wr_mask;
    logic          rd_mask;
    logic [31:0]   rd_val;

    assign wr_word       = s_axi_awaddr[ADDR_WIDTH-1:2];
    assign rd_word       = s_axi_araddr[ADDR_WIDTH-1:2];
    assign wr_fire       = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
    assign s_axi_awready = ~s_axi_bvalid;
    assign s_axi_wready  = ~s_axi_bvalid;
    assign s_axi_arready = ~s_axi_rvalid;
    assign s_axi_rlast   = s_axi_rvalid;
    assign soft_rst = wr_fire & (wr_word == A_SRST) & s_axi_wdata[0];
    assign en_rise  = wr_fire & (wr_word == A_CTRL) & s_axi_wdata[0] & ~enable;
    assign wr_mask  = (wr_word >= A_MASK) && (wr_word < A_MEND);
    assign rd_mask  = (rd_word >= A_MASK) && (rd_word < A_MEND);
    assign wr_tap   = TW'(wr_word - A_MASK);
    assign rd_tap   = TW'(rd_word - A_MASK);

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            enable <= 1'b0;
            width  <= '0;
            height <= '0;
            mask   <= '0;
        end else if (soft_rst) begin
            enable <= 1'b0;
            width  <= '0;
            height <= '0;
            mask   <= '0;
        end else if (wr_fire) begin
            unique case (1'b1)
                wr_word == A_CTRL: enable <= s_axi_wdata[0];
                wr_word == A_WID:  width  <= s_axi_wdata[15:0];
                wr_word == A_HGT:  height <= s_axi_wdata[15:0];
                wr_mask:           mask[wr_tap] <= |s_axi_wdata;
                default: ;
            endcase
        end
    end

    // The SRST write still gets its B response.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            s_axi_bvalid <= 1'b0;
        end else if (wr_fire) begin
            s_axi_bvalid <= 1'b1;
        end else if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
        end
    end

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            rd_word == A_CTRL: rd_val = {31'b0, enable};
            rd_word == A_STAT: rd_val = {30'b0, done, busy};
            rd_word == A_WID:  rd_val = {16'b0, width};
            rd_word == A_HGT:  rd_val = {16'b0, height};
            rd_mask:           rd_val = {31'b0, mask[rd_tap]};
            default:           rd_val = '0;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
        end else if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_val;
        end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

    logic                  beat;
    logic                  last_chan;
    logic                  last_col;
    logic                  last_row;
    logic                  frame_end;
    logic                  out_hit;
    logic [DATA_WIDTH-1:0] pixel;
    logic [DATA_WIDTH-1:0] pool;
    logic [LW-1:0]         lb_addr;
    logic [DATA_WIDTH-1:0] lb [K-1][DEPTH];
    logic [DATA_WIDTH-1:0] win [CHANNELS][K][K];
    logic [DATA_WIDTH-1:0] col_vec [K];
    logic [DATA_WIDTH-1:0] win_nx [K][K];

    assign s_axis_ready = enable & (~m_axis_valid | m_axis_ready);
    assign m_axis_keep  = m_axis_valid ? 4'hF : 4'h0;
    assign beat      = s_axis_valid & s_axis_ready;
    assign pixel     = s_axis_data[DATA_WIDTH-1:0];
    assign last_chan = chan == CH_LAST;
    assign last_col  = ({1'b0, col} + 17'd1) >= {1'b0, width};
    assign last_row  = ({1'b0, row} + 17'd1) >= {1'b0, height};
    assign frame_end = last_chan & last_col & last_row;
    assign out_hit   = (col >= K_M1) && (row >= K_M1) &&
                       (width >= K_DIM) && (height >= K_DIM);
    assign lb_addr   = LW'(int'(col) * CHANNELS + int'(chan));

    // Row 0 of the window is the oldest line; column K-1 is the newest pixel.
    always_comb begin
        col_vec[K-1] = pixel;
        for (int r = 0; r < K - 1; r++) begin
            col_vec[r] = lb[K-2-r][lb_addr];
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_nx[r][c] = win[chan][r][c+1];
            end
            win_nx[r][K-1] = col_vec[r];
        end
    end

    always_comb begin
        pool = '0;
        for (int i = 0; i < NT; i++) begin
            if (mask[i] && (win_nx[i/K][i%K] > pool)) begin
                pool = win_nx[i/K][i%K];
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (beat) begin
            lb[0][lb_addr] <= pixel;
            for (int j = 1; j < K - 1; j++) begin
                lb[j][lb_addr] <= lb[j-1][lb_addr];
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win[chan][r][c] <= win_nx[r][c];
                end
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            chan         <= '0;
            col          <= '0;
            row          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
            m_axis_data  <= '0;
        end else if (soft_rst) begin
            chan         <= '0;
            col          <= '0;
            row          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
            m_axis_data  <= '0;
        end else begin
            if (en_rise) begin
                done <= 1'b0;
            end
            if (m_axis_valid && m_axis_ready) begin
                m_axis_valid <= 1'b0;
                m_axis_last  <= 1'b0;
            end
            if (beat) begin
                if (out_hit) begin
                    m_axis_valid <= 1'b1;
                    m_axis_last  <= frame_end;
                    m_axis_data  <= 32'(pool);
                end
                busy <= ~frame_end;
                if (frame_end) begin
                    done <= 1'b1;
                end
                if (last_chan) begin
                    chan <= '0;
                    if (last_col) begin
                        col <= '0;
                        row <= last_row ? 16'd0 : row + 16'd1;
                    end else begin
                        col <= col + 16'd1;
                    end
                end else begin
                    chan <= chan + 1'b1;
                end
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{s_axis_last, s_axis_keep,
                         s_axis_data[31:DATA_WIDTH], s_axi_wdata,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_pooling_controller.sv
// Randomized bench for pooling_controller against a frame-level max-pool model.
// Outputs are scoreboarded from a queue built directly from the image array.
`timescale 1ns/1ps
module tb_pooling_controller;
    localparam int K = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_valid, s_ready, s_last;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        m_valid, m_last;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic [9:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic        arvalid, arready, rvalid, rready, rlast;

    int vectors = 0;
    int errors  = 0;
    int bp_mode = 0;
    int n_out   = 0;
    logic [16:0] exp_q [$];
    logic [15:0] img [$];

    pooling_controller dut (
        .axi_clk(clk), .axi_reset_n(rst_n),
        .s_axis_valid(s_valid), .s_axis_ready(s_ready),
        .s_axis_last(s_last), .s_axis_data(s_data), .s_axis_keep(s_keep),
        .m_axis_valid(m_valid), .m_axis_ready(m_ready),
        .m_axis_last(m_last), .m_axis_data(m_data), .m_axis_keep(m_keep),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_rlast(rlast)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0: m_ready = 1'b1;
            1: m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n && m_valid && m_ready) begin
            n_out++;
            check("keep", 32'(m_keep), 32'hF);
            if (exp_q.size() == 0) begin
                check("extra_out", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("data", m_data, {16'b0, e[15:0]});
                check("last", 32'(m_last), 32'(e[16]));
            end
        end
    end

    task automatic axi_write(input logic [9:0] addr, input logic [31:0] data);
        int t = 0;
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        while (!awready && t < 100) begin @(negedge clk); t++; end
        if (!awready) check("aw_timeout", 0, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!bvalid && t < 100) begin @(negedge clk); t++; end
        if (!bvalid) check("b_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [9:0] addr, output logic [31:0] data,
                            output logic lst);
        int t = 0;
        araddr = addr; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && t < 100) begin @(negedge clk); t++; end
        if (!arready) check("ar_timeout", 0, 1);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rvalid && t < 100) begin @(negedge clk); t++; end
        if (!rvalid) check("r_timeout", 0, 1);
        data = rdata; lst = rlast;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    // Reference: every full KxK window, max over enabled taps, zero if none.
    task automatic build_expect(input int w, input int h, input logic [8:0] m);
        for (int r = K - 1; r < h; r++) begin
            for (int c = K - 1; c < w; c++) begin
                logic [15:0] mx;
                logic [15:0] v;
                mx = 16'd0;
                for (int i = 0; i < K * K; i++) begin
                    v = img[(r - K + 1 + i / K) * w + (c - K + 1 + i % K)];
                    if (m[i] && v > mx) mx = v;
                end
                exp_q.push_back({(r == h - 1) && (c == w - 1), mx});
            end
        end
    endtask

    task automatic send_frame(input int n, input int pause_at);
        int t;
        for (int i = 0; i < n; i++) begin
            if (i == pause_at) begin
                axi_write(10'h00, 32'd0);
                @(negedge clk);
                check("pause_ready", 32'(s_ready), 0);
                @(posedge clk); #1;
                axi_write(10'h00, 32'd1);
            end
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            s_valid = 1'b1;
            s_data = {16'($urandom), img[i]};
            t = 0;
            @(negedge clk);
            while (!s_ready && t < 200) begin @(negedge clk); t++; end
            if (!s_ready) check("s_ready_timeout", 0, 1);
            @(posedge clk); #1;
            s_valid = 1'b0;
        end
    endtask

    // mode: 0 random image, 1 ramp, 2 reuse previous image
    task automatic run_frame(input int w, input int h, input logic [8:0] m,
                             input int mode, input int pause_at);
        int t = 0;
        int exp_n;
        logic [31:0] st;
        logic l;
        axi_write(10'h10, 32'(w));
        axi_write(10'h14, 32'(h));
        for (int i = 0; i < 9; i++)
            axi_write(10'(24 + 4 * i), m[i] ? $urandom_range(1, 255) : 0);
        axi_write(10'h00, 32'd1);
        if (mode != 2) begin
            img.delete();
            for (int i = 0; i < w * h; i++)
                img.push_back(mode == 1 ? 16'(i) : 16'($urandom));
        end
        build_expect(w, h, m);
        exp_n = exp_q.size();
        n_out = 0;
        send_frame(w * h, pause_at);
        while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        check("out_count", 32'(n_out), 32'(exp_n));
        axi_read(10'h08, st, l);
        check("status_done", st, 32'h2);
    endtask

    task automatic hold_probe();
        int t = 0;
        logic [31:0] d;
        while (!m_valid && t < 2000) begin @(negedge clk); t++; end
        bp_mode = 2;
        @(posedge clk);
        @(negedge clk);
        t = 0;
        while (!m_valid && t < 100) begin @(negedge clk); t++; end
        check("hold_valid", 32'(m_valid), 1);
        d = m_data;
        repeat (5) begin
            @(negedge clk);
            check("hold_data", m_data, d);
            check("hold_sready", 32'(s_ready), 0);
            check("hold_mvalid", 32'(m_valid), 1);
        end
        bp_mode = 0;
    endtask

    initial begin
        logic [31:0] d;
        logic l;
        logic [8:0] m;
        int w, h;
        s_valid = 0; s_last = 0; s_data = 0; s_keep = 4'hF;
        awaddr = 0; awvalid = 0; wdata = 0; wvalid = 0; bready = 1;
        araddr = 0; arvalid = 0; rready = 0;

        repeat (2) @(negedge clk);
        check("rst_sready", 32'(s_ready), 0);
        check("rst_mvalid", 32'(m_valid), 0);
        check("rst_mkeep", 32'(m_keep), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_awready", 32'(awready), 1);
        check("rst_arready", 32'(arready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        axi_write(10'h10, 32'd8);
        axi_read(10'h10, d, l);
        check("rd_width", d, 32'd8);
        check("rd_rlast", 32'(l), 1);
        axi_write(10'h3FC, 32'd123);
        axi_read(10'h3FC, d, l);
        check("rd_unmapped", d, 0);
        axi_read(10'h0C, d, l);
        check("rd_hole", d, 0);

        bp_mode = 0;
        run_frame(8, 8, 9'b000010000, 1, -1);
        run_frame(8, 8, 9'h1FF, 1, -1);

        axi_write(10'h00, 32'd0);
        axi_write(10'h00, 32'd1);
        axi_read(10'h08, d, l);
        check("done_clear", d, 0);

        fork
            run_frame(8, 8, 9'h1FF, 0, -1);
            hold_probe();
        join

        bp_mode = 1;
        run_frame(6, 5, 9'(($urandom & 9'h1FF) | 9'h1), 0, 10);
        run_frame(2, 6, 9'h1FF, 0, -1);
        run_frame(5, 2, 9'h1FF, 0, -1);
        for (int it = 0; it < 6; it++) begin
            w = $urandom_range(3, 10);
            h = $urandom_range(3, 9);
            m = 9'($urandom);
            run_frame(w, h, m, 0, -1);
        end

        bp_mode = 0;
        m = 9'($urandom);
        run_frame(7, 6, m, 0, -1);
        run_frame(7, 6, m, 2, -1);

        bready = 1'b0;
        awaddr = 10'h14; wdata = 32'd5; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check("bd_awready", 32'(awready), 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("bd_bvalid", 32'(bvalid), 1);
            check("bd_awblock", 32'(awready), 0);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(negedge clk);
        check("bd_bvalid_hold", 32'(bvalid), 1);
        @(posedge clk);
        @(negedge clk);
        check("bd_bclear", 32'(bvalid), 0);
        @(posedge clk); #1;
        axi_read(10'h14, d, l);
        check("bd_commit", d, 32'd5);

        axi_write(10'h00, 32'd1);
        axi_write(10'h10, 32'd8);
        axi_write(10'h04, 32'd1);
        axi_read(10'h00, d, l);
        check("srst_ctrl", d, 0);
        axi_read(10'h10, d, l);
        check("srst_width", d, 0);
        axi_read(10'h04, d, l);
        check("srst_reads0", d, 0);
        @(negedge clk);
        check("srst_sready", 32'(s_ready), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
